simple_fsm: RTL and testbench

- Timed sequencer: a rising edge on start launches a fixed sequence: wait DELAY_CYCLES, assert out for ACTIVE_CYCLES, then hold off for HOLDOFF_CYCLES before re-arming.
- Sits in the i2c_pipeline as a one-shot pulse generator driven by the local timer.
- Contains one internal down-counter timer shared by all timed states.

---
 rtl/simple_fsm.sv | 111 +++++++++++
 tb/tb_simple_fsm.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/simple_fsm.sv
// One-shot timed sequencer: a start rise runs DELAY -> ACTIVE -> HOLDOFF -> IDLE,
// with out high only while ACTIVE. A single down-counter times every state.
//
// state   | meaning
// IDLE    | armed, waiting for a start rise
// DELAY   | counting DELAY_CYCLES before the pulse
// ACTIVE  | out high for ACTIVE_CYCLES
// HOLDOFF | out low, starts ignored for HOLDOFF_CYCLES
module simple_fsm #(
  parameter int unsigned DELAY_CYCLES   = 10,
  parameter int unsigned ACTIVE_CYCLES  = 20,
  parameter int unsigned HOLDOFF_CYCLES = 5,
  parameter int unsigned TIMER_WIDTH    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic out
);

  // A zero cycle count is treated as one so every timed state lasts at least a cycle.
  localparam int unsigned D_EFF = (DELAY_CYCLES   == 0) ? 1 : DELAY_CYCLES;
  localparam int unsigned A_EFF = (ACTIVE_CYCLES  == 0) ? 1 : ACTIVE_CYCLES;
  localparam int unsigned H_EFF = (HOLDOFF_CYCLES == 0) ? 1 : HOLDOFF_CYCLES;

  localparam logic [TIMER_WIDTH-1:0] LD_DELAY   = TIMER_WIDTH'(D_EFF - 1);
  localparam logic [TIMER_WIDTH-1:0] LD_ACTIVE  = TIMER_WIDTH'(A_EFF - 1);
  localparam logic [TIMER_WIDTH-1:0] LD_HOLDOFF = TIMER_WIDTH'(H_EFF - 1);
  localparam logic [TIMER_WIDTH-1:0] T_ZERO     = '0;
  localparam logic [TIMER_WIDTH-1:0] T_ONE      = TIMER_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    ACTIVE  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic [TIMER_WIDTH-1:0] w_timer_nxt;
  logic                   r_out;
  logic                   w_out_nxt;
  logic                   r_start_q;
  logic                   w_start_rise;
  logic                   w_timer_done;

  assign w_start_rise = start & ~r_start_q;
  assign w_timer_done = (r_timer == T_ZERO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_timer   <= T_ZERO;
      r_out     <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_out     <= w_out_nxt;
      r_start_q <= start;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    w_timer_nxt = T_ZERO;
    w_out_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_rise) begin
          w_state_nxt = DELAY;
          w_timer_nxt = LD_DELAY;
        end
      end
      DELAY: begin
        if (w_timer_done) begin
          w_state_nxt = ACTIVE;
          w_timer_nxt = LD_ACTIVE;
          w_out_nxt   = 1'b1;
        end else begin
          w_state_nxt = DELAY;
          w_timer_nxt = r_timer - T_ONE;
        end
      end
      ACTIVE: begin
        if (w_timer_done) begin
          w_state_nxt = HOLDOFF;
          w_timer_nxt = LD_HOLDOFF;
        end else begin
          w_state_nxt = ACTIVE;
          w_timer_nxt = r_timer - T_ONE;
          w_out_nxt   = 1'b1;
        end
      end
      HOLDOFF: begin
        if (!w_timer_done) begin
          w_state_nxt = HOLDOFF;
          w_timer_nxt = r_timer - T_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign out = r_out;

endmodule

// File: tb/tb_simple_fsm.sv
// Directed bench for simple_fsm: default-parameter instance plus a 1/1/1 corner instance.
module tb_simple_fsm;

  logic clk;
  logic reset;
  logic start;
  logic out;
  logic start_c;
  logic out_c;

  int checks = 0;
  int errors = 0;

  simple_fsm dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .out   (out)
  );

  simple_fsm #(
    .DELAY_CYCLES   (1),
    .ACTIVE_CYCLES  (1),
    .HOLDOFF_CYCLES (1),
    .TIMER_WIDTH    (16)
  ) u_c (
    .clk   (clk),
    .reset (reset),
    .start (start_c),
    .out   (out_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  logic [1:0] st;
  logic       e;

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    start_c = 1'b0;

    // reset hold with start toggling
    for (int k = 0; k < 50; k++) begin
      start = ~start;
      tick();
      st = dut.r_state;
      chk("rst_out", k, {1'b0, out}, 2'd0);
      chk("rst_state", k, st, 2'd0);
    end
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("idle_out", 0, {1'b0, out}, 2'd0);

    // basic sequence with start held for 1000+ cycles
    start = 1'b1;
    for (int k = 0; k <= 1010; k++) begin
      tick();
      e = (k >= 10 && k < 30);
      chk("basic_held", k, {1'b0, out}, {1'b0, e});
      if (k == 35) begin
        st = dut.r_state;
        chk("basic_idle", k, st, 2'd0);
      end
    end
    start = 1'b0;
    tick();
    tick();

    // rises during ACTIVE and HOLDOFF ignored, fresh rise at edge N+38 accepted
    start = 1'b1;
    for (int k = 0; k <= 75; k++) begin
      tick();
      e = (k >= 10 && k < 30) || (k >= 48 && k < 68);
      chk("rearm", k, {1'b0, out}, {1'b0, e});
      case (k)
        13, 30, 36: start = 1'b0;
        14, 31, 37: start = 1'b1;
        default: ;
      endcase
    end
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    // async abort mid-ACTIVE
    start = 1'b1;
    for (int k = 0; k <= 15; k++) tick();
    chk("abort_pre", 15, {1'b0, out}, 2'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_out", 0, {1'b0, out}, 2'd0);
    st = dut.r_state;
    chk("abort_state", 0, st, 2'd0);
    tick();
    chk("abort_hold", 0, {1'b0, out}, 2'd0);
    reset = 1'b1;
    for (int k = 0; k <= 36; k++) begin
      tick();
      e = (k >= 10 && k < 30);
      chk("post_abort", k, {1'b0, out}, {1'b0, e});
    end
    start = 1'b0;
    tick();

    // 1/1/1 corner
    start_c = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      tick();
      e = (k == 1);
      chk("corner_out", k, {1'b0, out_c}, {1'b0, e});
      if (k == 2) begin
        st = u_c.r_state;
        chk("corner_hold", k, st, 2'd3);
      end
      if (k == 3) begin
        st = u_c.r_state;
        chk("corner_idle", k, st, 2'd0);
      end
    end
    start_c = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
